// File: rtl/sal_rw_scheduler.sv
// Read/write request scheduler: arbitrates AR and AW into a one-entry bank request slot,
// gating writes on buffered write data and bounding read/write starvation.
module sal_rw_scheduler #(
    parameter int ID_WIDTH     = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int LEN_WIDTH    = 4,
    parameter int WCNT_WIDTH   = 5,
    parameter int STARVE_LIMIT = 8,
    parameter int WR_BURST     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ar_valid,
    input  logic [ID_WIDTH-1:0]   ar_id,
    input  logic [ADDR_WIDTH-1:0] ar_addr,
    input  logic [LEN_WIDTH-1:0]  ar_len,
    output logic                  ar_ready,
    input  logic                  aw_valid,
    input  logic [ID_WIDTH-1:0]   aw_id,
    input  logic [ADDR_WIDTH-1:0] aw_addr,
    input  logic [LEN_WIDTH-1:0]  aw_len,
    output logic                  aw_ready,
    input  logic                  w_valid,
    input  logic                  w_ready,
    input  logic                  w_last,
    output logic                  w_hold,
    output logic                  req_valid,
    output logic [ID_WIDTH-1:0]   req_id,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [LEN_WIDTH-1:0]  req_len,
    output logic                  req_wr,
    input  logic                  req_ready,
    output logic [WCNT_WIDTH-1:0] wcnt,
    output logic                  wr_prio
);
    localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int BC_W = (WR_BURST < 1) ? 1 : $clog2(WR_BURST + 1);
    localparam logic [WCNT_WIDTH-1:0] WCNT_MAX = {WCNT_WIDTH{1'b1}};
    localparam logic [WCNT_WIDTH-1:0] WCNT_ONE = WCNT_WIDTH'(1);
    localparam logic [SC_W-1:0]       SC_ONE   = SC_W'(1);
    localparam logic [SC_W-1:0]       SC_LIMIT = SC_W'(STARVE_LIMIT);
    localparam logic [BC_W-1:0]       BC_ONE   = BC_W'(1);
    localparam logic [BC_W-1:0]       BC_LIMIT = BC_W'(WR_BURST);

    typedef enum logic {
        RD_PRIO = 1'b0,
        WR_PRIO = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    run_q, run_d;
    logic [WCNT_WIDTH-1:0]   wcnt_q, wcnt_d;
    logic [SC_W-1:0]         starve_cnt_q, starve_cnt_d;
    logic [BC_W-1:0]         wrb_cnt_q, wrb_cnt_d;
    logic                    req_valid_q, req_valid_d;
    logic                    req_wr_q, req_wr_d;
    logic [ID_WIDTH-1:0]     req_id_q, req_id_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic [LEN_WIDTH-1:0]    req_len_q, req_len_d;

    logic wr_elig, slot_free, grant_rd, grant_wr;
    logic ar_hs, aw_hs, wlast_hs;

    assign w_hold    = (wcnt_q == WCNT_MAX);
    assign wcnt      = wcnt_q;
    assign wr_prio   = (state_q == WR_PRIO);
    assign req_valid = req_valid_q;
    assign req_wr    = req_wr_q;
    assign req_id    = req_id_q;
    assign req_addr  = req_addr_q;
    assign req_len   = req_len_q;

    // Grant selection; run_q keeps both channels closed for the first cycle out of reset.
    always_comb begin
        wr_elig   = aw_valid & (wcnt_q != '0);
        slot_free = ~req_valid_q | req_ready;
        grant_rd  = 1'b0;
        grant_wr  = 1'b0;
        if (state_q == WR_PRIO) begin
            grant_wr = wr_elig;
            grant_rd = ~wr_elig & ar_valid;
        end else begin
            grant_rd = ar_valid;
            grant_wr = ~ar_valid & wr_elig;
        end
        ar_ready = run_q & slot_free & grant_rd;
        aw_ready = run_q & slot_free & grant_wr;
        ar_hs    = ar_valid & ar_ready;
        aw_hs    = aw_valid & aw_ready;
        wlast_hs = w_valid & w_ready & w_last;
    end

    always_comb begin
        run_d  = 1'b1;
        wcnt_d = wcnt_q;
        if (wlast_hs & ~aw_hs) begin
            if (wcnt_q != WCNT_MAX) wcnt_d = wcnt_q + WCNT_ONE;
        end else if (aw_hs & ~wlast_hs) begin
            wcnt_d = wcnt_q - WCNT_ONE;
        end

        req_valid_d = req_valid_q;
        req_wr_d    = req_wr_q;
        req_id_d    = req_id_q;
        req_addr_d  = req_addr_q;
        req_len_d   = req_len_q;
        if (ar_hs) begin
            req_valid_d = 1'b1;
            req_wr_d    = 1'b0;
            req_id_d    = ar_id;
            req_addr_d  = ar_addr;
            req_len_d   = ar_len;
        end else if (aw_hs) begin
            req_valid_d = 1'b1;
            req_wr_d    = 1'b1;
            req_id_d    = aw_id;
            req_addr_d  = aw_addr;
            req_len_d   = aw_len;
        end else if (req_ready) begin
            req_valid_d = 1'b0;
        end
    end

    // Mode switches are decided on the same edge as the grant that reaches a limit.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        wrb_cnt_d    = wrb_cnt_q;
        case (state_q)
            RD_PRIO: begin
                wrb_cnt_d = '0;
                if (aw_hs) starve_cnt_d = '0;
                else if (ar_hs & wr_elig) starve_cnt_d = starve_cnt_q + SC_ONE;
                if ((starve_cnt_d >= SC_LIMIT) | w_hold) state_d = WR_PRIO;
            end
            WR_PRIO: begin
                if (aw_hs) begin
                    wrb_cnt_d    = wrb_cnt_q + BC_ONE;
                    starve_cnt_d = '0;
                end
                if ((wrb_cnt_d >= BC_LIMIT) | (~wr_elig & ~w_hold)) begin
                    state_d      = RD_PRIO;
                    starve_cnt_d = '0;
                end
            end
            default: state_d = RD_PRIO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RD_PRIO;
            run_q        <= 1'b0;
            wcnt_q       <= '0;
            starve_cnt_q <= '0;
            wrb_cnt_q    <= '0;
            req_valid_q  <= 1'b0;
            req_wr_q     <= 1'b0;
            req_id_q     <= '0;
            req_addr_q   <= '0;
            req_len_q    <= '0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            wcnt_q       <= wcnt_d;
            starve_cnt_q <= starve_cnt_d;
            wrb_cnt_q    <= wrb_cnt_d;
            req_valid_q  <= req_valid_d;
            req_wr_q     <= req_wr_d;
            req_id_q     <= req_id_d;
            req_addr_q   <= req_addr_d;
            req_len_q    <= req_len_d;
        end
    end
endmodule

// File: tb/tb_sal_rw_scheduler.sv
// Scoreboard bench for sal_rw_scheduler: a cycle model of the arbitration rules predicts
// grants and handshake readiness; a monitor checks each accepted bank request.
module tb_sal_rw_scheduler;
    localparam int IDW  = 4;
    localparam int AW   = 32;
    localparam int LW   = 4;
    localparam int WCW  = 5;
    localparam int SL   = 8;
    localparam int WB   = 4;
    localparam int WMAX = 31;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ar_valid, aw_valid, w_valid, w_ready, w_last, req_ready;
    logic [IDW-1:0] ar_id, aw_id;
    logic [AW-1:0]  ar_addr, aw_addr;
    logic [LW-1:0]  ar_len, aw_len;
    logic           ar_ready, aw_ready, w_hold, req_valid, req_wr, wr_prio;
    logic [IDW-1:0] req_id;
    logic [AW-1:0]  req_addr;
    logic [LW-1:0]  req_len;
    logic [WCW-1:0] wcnt;

    always #5 clk = ~clk;

    sal_rw_scheduler #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .WCNT_WIDTH(WCW),
        .STARVE_LIMIT(SL), .WR_BURST(WB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ar_valid(ar_valid), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_ready(ar_ready),
        .aw_valid(aw_valid), .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_ready(aw_ready),
        .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last), .w_hold(w_hold),
        .req_valid(req_valid), .req_id(req_id), .req_addr(req_addr), .req_len(req_len),
        .req_wr(req_wr), .req_ready(req_ready),
        .wcnt(wcnt), .wr_prio(wr_prio)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic [LW-1:0]  len;
        logic           wr;
    } item_t;

    item_t sb_q[$];
    int    errors = 0;
    int    checks = 0;
    bit    rec_on = 1'b0;
    bit    rec[$];

    // Reference state: mode, pending write bursts, starvation/burst tallies, slot occupancy.
    bit m_wrmode, m_run, m_slot;
    int m_pend, m_starve, m_burst;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit hold, elig, sfree, want_rd, want_wr, e_ar, e_aw, wl;
        if (!rst_n) begin
            m_wrmode = 0; m_run = 0; m_slot = 0;
            m_pend = 0; m_starve = 0; m_burst = 0;
            sb_q.delete();
        end else begin
            hold  = (m_pend == WMAX);
            elig  = aw_valid && (m_pend > 0);
            sfree = !m_slot || req_ready;
            if (m_wrmode) begin
                want_wr = elig;
                want_rd = ar_valid && !elig;
            end else begin
                want_rd = ar_valid;
                want_wr = elig && !ar_valid;
            end
            e_ar = m_run && sfree && want_rd;
            e_aw = m_run && sfree && want_wr;
            wl   = w_valid && w_ready && w_last;

            chk("ar_ready", ar_ready, e_ar);
            chk("aw_ready", aw_ready, e_aw);
            chk("req_valid", req_valid, m_slot);
            chk("wcnt", wcnt, m_pend);
            chk("w_hold", w_hold, hold);
            chk("wr_prio", wr_prio, m_wrmode);

            if (wl && !e_aw) begin
                if (m_pend < WMAX) m_pend++;
            end else if (e_aw && !wl) begin
                m_pend--;
            end

            if (e_ar) sb_q.push_back('{id: ar_id, addr: ar_addr, len: ar_len, wr: 1'b0});
            if (e_aw) sb_q.push_back('{id: aw_id, addr: aw_addr, len: aw_len, wr: 1'b1});
            if (e_ar || e_aw) m_slot = 1;
            else if (req_ready) m_slot = 0;

            if (!m_wrmode) begin
                if (e_aw) m_starve = 0;
                else if (e_ar && elig) m_starve++;
                if (m_starve >= SL || hold) begin
                    m_wrmode = 1;
                    m_burst  = 0;
                end
            end else begin
                if (e_aw) begin
                    m_burst++;
                    m_starve = 0;
                end
                if (m_burst >= WB || (!elig && !hold)) begin
                    m_wrmode = 0;
                    m_starve = 0;
                end
            end
            m_run = 1;
        end
    end

    always @(negedge clk) begin
        item_t e;
        if (rst_n && req_valid && req_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_req", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("req_wr", req_wr, e.wr);
                chk("req_id", req_id, e.id);
                chk("req_addr", req_addr, e.addr);
                chk("req_len", req_len, e.len);
                $display("txn %s id=%0h addr=%08h len=%0d", req_wr ? "WR" : "RD", req_id, req_addr, req_len);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rec_on) begin
            if (ar_valid && ar_ready) rec.push_back(1'b0);
            if (aw_valid && aw_ready) rec.push_back(1'b1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        ar_valid = 0; aw_valid = 0; w_valid = 0; w_ready = 0; w_last = 0; req_ready = 1;
    endtask

    task automatic rand_addr();
        ar_id = IDW'($urandom); ar_addr = $urandom; ar_len = LW'($urandom);
        aw_id = IDW'($urandom); aw_addr = $urandom; aw_len = LW'($urandom);
    endtask

    task automatic wlast_pulse(input int n);
        w_valid = 1; w_ready = 1; w_last = 1;
        for (int i = 0; i < n; i++) tick();
        w_valid = 0; w_ready = 0; w_last = 0;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        set_idle();
        rand_addr();
        ar_valid = 1;
        aw_valid = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", req_valid, 0);
        chk("rst_req_wr", req_wr, 0);
        chk("rst_req_id", req_id, 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_req_len", req_len, 0);
        chk("rst_ar_ready", ar_ready, 0);
        chk("rst_aw_ready", aw_ready, 0);
        chk("rst_wcnt", wcnt, 0);
        chk("rst_w_hold", w_hold, 0);
        chk("rst_wr_prio", wr_prio, 0);
        set_idle();
        rst_n = 1;
        tick();
        tick();

        // Write address waits for its data, then issues one cycle after the handshake.
        rand_addr();
        aw_valid = 1;
        tick();
        tick();
        chk("aw_blocked_no_data", aw_ready, 0);
        wlast_pulse(1);
        chk("wcnt_after_wlast", wcnt, 1);
        chk("aw_ready_after_wlast", aw_ready, 1);
        tick();
        aw_valid = 0;
        chk("wr_req_valid", req_valid, 1);
        chk("wr_req_wr", req_wr, 1);
        chk("wcnt_after_aw", wcnt, 0);
        tick();

        // Simultaneous data-last and address handshake leaves the count unchanged.
        wlast_pulse(3);
        chk("wcnt_preload3", wcnt, 3);
        rand_addr();
        aw_valid = 1;
        w_valid = 1; w_ready = 1; w_last = 1;
        tick();
        set_idle();
        chk("wcnt_both_hs", wcnt, 3);
        tick();

        // Saturating read pressure: 8 reads, 4 writes, repeat.
        wlast_pulse(7);
        chk("wcnt_preload10", wcnt, 10);
        rec.delete();
        rec_on = 1;
        ar_valid = 1;
        aw_valid = 1;
        for (int i = 0; i < 24; i++) begin
            rand_addr();
            tick();
        end
        rec_on = 0;
        set_idle();
        chk("grant_count", rec.size(), 24);
        for (int i = 0; i < 24 && i < rec.size(); i++) begin
            bit exp_wr;
            exp_wr = ((i % 12) >= 8);
            chk($sformatf("grant_seq_%0d", i), rec[i], exp_wr);
        end
        tick();

        // Back-pressure on the slot blocks both channels.
        rand_addr();
        ar_valid = 1;
        aw_valid = 1;
        req_ready = 0;
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk("stall_ar_ready", ar_ready, 0);
        chk("stall_aw_ready", aw_ready, 0);
        chk("stall_req_valid", req_valid, 1);
        req_ready = 1;
        tick();
        tick();
        set_idle();
        tick();

        // Pending count saturates and forces write priority.
        do_reset();
        wlast_pulse(35);
        chk("wcnt_saturated", wcnt, WMAX);
        chk("w_hold_saturated", w_hold, 1);
        chk("wr_prio_on_hold", wr_prio, 1);
        tick();

        for (int c = 0; c < 2000; c++) begin
            rand_addr();
            ar_valid  = ($urandom_range(0, 99) < 55);
            aw_valid  = ($urandom_range(0, 99) < 60);
            w_valid   = ($urandom_range(0, 99) < 50) && (!w_hold || $urandom_range(0, 9) == 0);
            w_ready   = ($urandom_range(0, 99) < 75);
            w_last    = ($urandom_range(0, 99) < 50);
            req_ready = ($urandom_range(0, 99) < 70);
            tick();
        end
        set_idle();
        tick();

        // Reset during operation drops the pending request and count.
        do_reset();
        wlast_pulse(5);
        rand_addr();
        ar_valid = 1;
        req_ready = 0;
        tick();
        tick();
        chk("pre_rst_req_valid", req_valid, 1);
        chk("pre_rst_wcnt", wcnt, 5);
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_req_valid", req_valid, 0);
        chk("mid_rst_wcnt", wcnt, 0);
        chk("mid_rst_wr_prio", wr_prio, 0);
        chk("mid_rst_ar_ready", ar_ready, 0);
        tick();
        tick();
        rst_n = 1;
        req_ready = 1;
        tick();
        chk("post_rst_no_req", req_valid, 0);
        tick();
        tick();
        set_idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sal_rw_scheduler.md
SAL_RW_SCHEDULER -- requirements
Module: sal_rw_scheduler

Interface
REQ-001 Parameters SHALL be: ID_WIDTH, default 4, AXI ID width.
REQ-002 Parameters SHALL be: ADDR_WIDTH, default 32, request address width.
REQ-003 Parameters SHALL be: LEN_WIDTH, default 4, AXI burst length width.
REQ-004 Parameters SHALL be: WCNT_WIDTH, default 5, pending write-data counter width.
REQ-005 Parameters SHALL be: STARVE_LIMIT, default 8, consecutive read grants allowed while a write is eligible.
REQ-006 Parameters SHALL be: WR_BURST, default 4, maximum consecutive write grants in write-priority mode.
REQ-007 Clock and reset SHALL be: clk in 1, the single clock; rst_n in 1, asynchronous active-low reset.
REQ-008 Read-address ports SHALL be: ar_valid in 1; ar_id in ID_WIDTH; ar_addr in ADDR_WIDTH; ar_len in LEN_WIDTH; ar_ready out 1.
REQ-009 Write-address ports SHALL be: aw_valid in 1; aw_id in ID_WIDTH; aw_addr in ADDR_WIDTH; aw_len in LEN_WIDTH; aw_ready out 1.
REQ-010 Write-data snoop ports SHALL be: w_valid in 1; w_ready in 1; w_last in 1; w_hold out 1, asserted requests that the upstream stall W.
REQ-011 Bank-request ports SHALL be: req_valid out 1; req_id out ID_WIDTH; req_addr out ADDR_WIDTH; req_len out LEN_WIDTH; req_wr out 1; req_ready in 1.
REQ-012 Status ports SHALL be: wcnt out WCNT_WIDTH, the pending-write count; wr_prio out 1, high in WR_PRIO.

Function
REQ-013 wlast_hs SHALL be defined as w_valid & w_ready & w_last; aw_hs as aw_valid & aw_ready; ar_hs as ar_valid & ar_ready.
REQ-014 wcnt SHALL increment by 1 on wlast_hs without aw_hs, decrement by 1 on aw_hs without wlast_hs, and hold when both or neither occur.
REQ-015 w_hold SHALL equal (wcnt == 2^WCNT_WIDTH-1); a wlast_hs while wcnt is at maximum SHALL leave wcnt saturated.
REQ-016 A write SHALL be eligible only when aw_valid & (wcnt != 0), using the registered wcnt, so wcnt never underflows.
REQ-017 The output slot SHALL be a one-entry register; slot_free = ~req_valid | req_ready.
REQ-018 At most one of ar_ready and aw_ready SHALL be high in any cycle, and each SHALL be high only when slot_free and that side is granted.
REQ-019 On a grant, the slot SHALL load id/addr/len from the granted channel, set req_wr (1 write, 0 read) and set req_valid on the next clk edge; latency is exactly 1 cycle.
REQ-020 req_valid SHALL clear on req_valid & req_ready with no new grant; slot contents SHALL be stable while req_valid & ~req_ready.
REQ-021 FSM states SHALL be RD_PRIO (reset state) and WR_PRIO.
REQ-022 In RD_PRIO, the grant SHALL go to read if ar_valid, else to write if eligible.
REQ-023 In WR_PRIO, the grant SHALL go to write if eligible, else to read if ar_valid.
REQ-024 starve_cnt SHALL increment on each read grant in RD_PRIO while a write is eligible, and clear on any write grant or on entry to RD_PRIO.
REQ-025 RD_PRIO SHALL transition to WR_PRIO when starve_cnt reaches STARVE_LIMIT or when w_hold is high.
REQ-026 wrb_cnt SHALL count write grants in WR_PRIO and clear on entry to WR_PRIO.
REQ-027 WR_PRIO SHALL return to RD_PRIO after WR_BURST write grants, or in any cycle with no eligible write while w_hold is low.
REQ-028 Counters SHALL be sized to hold STARVE_LIMIT and WR_BURST with no wrap.

Reset
REQ-029 While rst_n is low, all of the following SHALL be 0 asynchronously: req_valid, req_wr, req_id, req_addr, req_len, ar_ready, aw_ready, wcnt, w_hold, starve_cnt, wrb_cnt; the FSM SHALL be in RD_PRIO with wr_prio 0.
REQ-030 Reset asserted mid-operation SHALL discard the slot content and the pending count; no request SHALL be issued in the first cycle after deassertion.

Verification
REQ-031 aw_valid=1 with wcnt=0, ar_valid=0 -> aw_ready stays 0; one wlast_hs -> wcnt=1, aw_ready=1 next cycle, and req_wr=1 with req_valid one cycle after aw_hs.
REQ-032 ar_valid held, req_ready=1 -> ar_ready every cycle, req_valid one cycle after each ar_hs, req_addr matching ar_addr.
REQ-033 ar_valid and an eligible write held continuously -> exactly 8 read grants, then WR_PRIO and 4 write grants, then RD_PRIO.
REQ-034 req_ready=0 with req_valid=1 -> ar_ready=aw_ready=0 and slot held stable; req_ready=1 -> the next grant loads in the same cycle.
REQ-035 wlast_hs and aw_hs in the same cycle with wcnt=3 -> wcnt stays 3; 31 wlast_hs from 0 -> w_hold=1 and WR_PRIO.
REQ-036 rst_n pulsed low with req_valid=1 and wcnt=5 -> req_valid=0 and wcnt=0 immediately; state RD_PRIO.
